// File: rtl/stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd
//
// Purpose:
//   Start/pause/clear stopwatch fed by the toggle output of an upstream
//   modulo-M divider. Each transition of sync_in (rising or falling) is one
//   tick. Ticks are counted in a cascaded BCD counter while running. A lap
//   register can freeze the displayed value while the live count keeps going.
//
// Optional build macro:
//   STOPWATCH_SEXAGESIMAL_EN - digit 1 wraps 5->0, so digits 1:0 are seconds
//   00-59 and the digits above are minutes. Full scale then reads 9959 for
//   four digits. This mode needs DIGITS >= 2.
//
// Parameters:
//   DIGITS - number of cascaded BCD digits (digit 0 least significant)
//   W      - 4*DIGITS, width of the BCD buses (derived; leave at default)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   sync_in    in   divider toggle; every transition is a tick
//   start_stop in   one-cycle pulse: start / pause / resume
//   clear      in   one-cycle pulse: zero the count when not running
//   lap        in   one-cycle pulse: freeze / release the displayed value
//   disp       out  BCD display value (lap register when held, else count)
//   running    out  high while in RUN
//   lap_hold   out  high while the display is frozen
//   ovf        out  sticky full-scale wrap flag
// -----------------------------------------------------------------------------
module stopwatch_bcd #(
  parameter int DIGITS = 4,
  parameter int W      = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sync_in,
  input  logic         start_stop,
  input  logic         clear,
  input  logic         lap,
  output logic [W-1:0] disp,
  output logic         running,
  output logic         lap_hold,
  output logic         ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         sync_prev_q, sync_prev_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] lap_q, lap_d;
  logic         lap_hold_q, lap_hold_d;
  logic         ovf_q, ovf_d;
  logic         running_q, running_d;
  logic         tick;
  logic [W:0]   inc;

  // Ripple-carry BCD increment. Returns {carry_out, incremented value}; the
  // carry out of the top digit marks a full-scale wrap. A digit at or above
  // its limit rolls to zero, so a corrupted digit can never persist.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    logic [3:0]   dig;
    logic [3:0]   lim;
    r     = v;
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      dig = v[4*k +: 4];
      lim = 4'd9;
`ifdef STOPWATCH_SEXAGESIMAL_EN
      if (k == 1) lim = 4'd5;
`else
`endif
      if (carry) begin
        if (dig >= lim) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = dig + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return {carry, r};
  endfunction

  // Either direction of the divider toggle is a tick.
  assign tick = sync_in ^ sync_prev_q;
  assign inc  = bcd_inc(count_q);

  always_comb begin
    state_d     = state_q;
    sync_prev_d = sync_in;
    count_d     = count_q;
    lap_d       = lap_q;
    lap_hold_d  = lap_hold_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      IDLE: begin
        // Lap is ignored here; clear together with start gives RUN from zero.
        if (clear) begin
          count_d = '0;
          ovf_d   = 1'b0;
        end
        if (start_stop) state_d = RUN;
      end
      RUN: begin
        // Lap captures the pre-increment count of this edge.
        if (lap) begin
          if (!lap_hold_q) begin
            lap_d      = count_q;
            lap_hold_d = 1'b1;
          end else begin
            lap_hold_d = 1'b0;
          end
        end
        // Counting depends on the pre-edge state, so a tick that coincides
        // with the pause pulse is still counted. Clear is ignored.
        if (tick) begin
          count_d = inc[W-1:0];
          if (inc[W]) ovf_d = 1'b1;
        end
        if (start_stop) state_d = PAUSE;
      end
      PAUSE: begin
        // Clear wins over start_stop.
        if (clear) begin
          state_d    = IDLE;
          count_d    = '0;
          ovf_d      = 1'b0;
          lap_hold_d = 1'b0;
        end else begin
          if (start_stop) state_d = RUN;
          if (lap) lap_hold_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_prev_q <= 1'b0;
      count_q     <= '0;
      lap_q       <= '0;
      lap_hold_q  <= 1'b0;
      ovf_q       <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_prev_q <= sync_prev_d;
      count_q     <= count_d;
      lap_q       <= lap_d;
      lap_hold_q  <= lap_hold_d;
      ovf_q       <= ovf_d;
      running_q   <= running_d;
    end
  end

  assign disp     = lap_hold_q ? lap_q : count_q;
  assign running  = running_q;
  assign lap_hold = lap_hold_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_bcd
//
// Scoreboard bench for stopwatch_bcd (DIGITS=4). The driver applies inputs on
// the falling edge, advances an integer-valued stopwatch model and queues the
// expected post-edge outputs; a monitor pops one entry after every rising edge
// that has one queued and compares. Directed checkpoints from the test plan
// compare against literal BCD values.
// -----------------------------------------------------------------------------
module tb_stopwatch_bcd;

  localparam int W = 16;
`ifdef STOPWATCH_SEXAGESIMAL_EN
  localparam int         MODV     = 6000;
  localparam logic [15:0] FULL_BCD = 16'h9959;
  localparam logic [15:0] AFTER59  = 16'h0100;
`else
  localparam int         MODV     = 10000;
  localparam logic [15:0] FULL_BCD = 16'h9999;
  localparam logic [15:0] AFTER59  = 16'h0060;
`endif

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sync_in = 1'b0;
  logic         start_stop = 1'b0;
  logic         clear = 1'b0;
  logic         lap = 1'b0;
  logic [W-1:0] disp;
  logic         running;
  logic         lap_hold;
  logic         ovf;

  stopwatch_bcd #(.DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_in    (sync_in),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .disp       (disp),
    .running    (running),
    .lap_hold   (lap_hold),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] disp;
    logic        running;
    logic        lap_hold;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: elapsed ticks as a plain integer.
  int   m_st;
  int   m_val;
  int   m_lap;
  bit   m_lh;
  bit   m_ovf;
  bit   m_syncd;
  logic sync_v = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    int d3, d2, d1, d0;
`ifdef STOPWATCH_SEXAGESIMAL_EN
    d3 = (v / 60) / 10;
    d2 = (v / 60) % 10;
    d1 = (v % 60) / 10;
    d0 = (v % 60) % 10;
`else
    d3 = (v / 1000) % 10;
    d2 = (v / 100) % 10;
    d1 = (v / 10) % 10;
    d0 = v % 10;
`endif
    return {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_val = 0; m_lap = 0; m_lh = 0; m_ovf = 0; m_syncd = 0;
  endtask

  // Drive one cycle of inputs (caller is at a falling edge) and queue the
  // expected outputs after the next rising edge.
  task automatic drive_cycle(input logic ss, input logic clr, input logic lp, input logic tog);
    bit   tk;
    exp_t e;
    if (tog) sync_v = ~sync_v;
    sync_in = sync_v; start_stop = ss; clear = clr; lap = lp;
    tk = (sync_v != m_syncd);
    m_syncd = sync_v;
    case (m_st)
      S_IDLE: begin
        if (clr) begin m_val = 0; m_ovf = 0; end
        if (ss) m_st = S_RUN;
      end
      S_RUN: begin
        if (lp) begin
          if (!m_lh) begin m_lap = m_val; m_lh = 1; end
          else m_lh = 0;
        end
        if (tk) begin
          m_val = m_val + 1;
          if (m_val == MODV) begin m_val = 0; m_ovf = 1; end
        end
        if (ss) m_st = S_PAUSE;
      end
      default: begin
        if (clr) begin m_st = S_IDLE; m_val = 0; m_ovf = 0; m_lh = 0; end
        else begin
          if (ss) m_st = S_RUN;
          if (lp) m_lh = 0;
        end
      end
    endcase
    e.disp     = to_bcd(m_lh ? m_lap : m_val);
    e.running  = (m_st == S_RUN);
    e.lap_hold = m_lh;
    e.ovf      = m_ovf;
    q.push_back(e);
  endtask

  task automatic step(input logic ss, input logic clr, input logic lp, input logic tog);
    @(negedge clk);
    drive_cycle(ss, clr, lp, tog);
  endtask

  task automatic run_ticks(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [15:0] e_disp, input logic e_run,
                     input logic e_lh, input logic e_ovf);
    checks++;
    if ({disp, running, lap_hold, ovf} !== {e_disp, e_run, e_lh, e_ovf}) begin
      errors++;
      $display("FAIL %s: got disp=%h running=%b lap_hold=%b ovf=%b, expected disp=%h running=%b lap_hold=%b ovf=%b",
               name, disp, running, lap_hold, ovf, e_disp, e_run, e_lh, e_ovf);
    end
  endtask

  // Check right after the edge of the most recently driven cycle.
  task automatic chk_edge(input string name, input logic [15:0] e_disp, input logic e_run,
                          input logic e_lh, input logic e_ovf);
    @(posedge clk);
    #2;
    chk(name, e_disp, e_run, e_lh, e_ovf);
  endtask

  // Scoreboard monitor.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({disp, running, lap_hold, ovf} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got disp=%h running=%b lap_hold=%b ovf=%b, expected disp=%h running=%b lap_hold=%b ovf=%b",
                 $time, disp, running, lap_hold, ovf, e.disp, e.running, e.lap_hold, e.ovf);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #1;
    chk("reset_initial", 16'h0000, 1'b0, 1'b0, 1'b0);
    chk_edge("reset_held", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Tick detection with a divider of M=10.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0, (i % 10) == 9);
    chk_edge("tick_m10", 16'h0003, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, (i % 10) == 9);
    chk_edge("count5", 16'h0005, 1'b1, 1'b0, 1'b0);

    // Pause, ticks while paused, resume.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_edge("paused", 16'h0005, 1'b0, 1'b0, 1'b0);
    run_ticks(4);
    chk_edge("paused_ticks", 16'h0005, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_edge("resumed", 16'h0005, 1'b1, 1'b0, 1'b0);
    run_ticks(1);
    chk_edge("resume_tick", 16'h0006, 1'b1, 1'b0, 1'b0);

    // Lap hold and release; clear ignored while running.
    run_ticks(6);
    chk_edge("count12", 16'h0012, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_edge("lap_set", 16'h0012, 1'b1, 1'b1, 1'b0);
    run_ticks(5);
    chk_edge("lap_frozen", 16'h0012, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_edge("clear_in_run", 16'h0012, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_edge("lap_release", 16'h0017, 1'b1, 1'b0, 1'b0);

    // Pause pulse coinciding with a tick: tick counted.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk_edge("pause_with_tick", 16'h0018, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_edge("clear_beats_start", 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_edge("idle_start_clear", 16'h0000, 1'b1, 1'b0, 1'b0);

    // Carries and full-scale wrap.
    run_ticks(9);
    chk_edge("count9", 16'h0009, 1'b1, 1'b0, 1'b0);
    run_ticks(1);
    chk_edge("carry_10", 16'h0010, 1'b1, 1'b0, 1'b0);
    run_ticks(49);
    chk_edge("count59", 16'h0059, 1'b1, 1'b0, 1'b0);
    run_ticks(1);
    chk_edge("after59", AFTER59, 1'b1, 1'b0, 1'b0);
    run_ticks(MODV - 1 - 60);
    chk_edge("full_scale", FULL_BCD, 1'b1, 1'b0, 1'b0);
    run_ticks(1);
    chk_edge("wrap_ovf", 16'h0000, 1'b1, 1'b0, 1'b1);
    run_ticks(2);
    chk_edge("ovf_sticky", 16'h0002, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_edge("ovf_paused", 16'h0002, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_edge("clear_ovf", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-run.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(7);
    chk_edge("pre_rst", 16'h0007, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 chk("rst_async", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 13) == 0, $urandom_range(0, 2) == 0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
